// File: rtl/multicycle_controller.sv
// Sequencing controller for a multicycle RV32I datapath: a Moore FSM that
// drives every datapath select and write strobe, decodes the ALU operation,
// and resolves branches from the ALU flags in the BRANCH state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       C,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    state_t state_n;

    // Raw per-state controls before reset gating of the strobes
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_op;

    // ALU operation: add for address/PC math, sub for compare, funct3-driven for ALU ops
    function automatic logic [2:0] alu_decode(input logic [1:0] aop,
                                              input logic [2:0] f3,
                                              input logic       op5,
                                              input logic       f7b5);
        logic [2:0] ctl;
        ctl = 3'b000;
        case (aop)
            2'b00: ctl = 3'b000;
            2'b01: ctl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010,
                    3'b011:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Branch condition from the flags of rs1 - rs2; unsigned compares use carry as not-borrow
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       zf,
                                          input logic       nf,
                                          input logic       vf,
                                          input logic       cf);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:  t = zf;
            3'b001:  t = ~zf;
            3'b100:  t = nf ^ vf;
            3'b101:  t = ~(nf ^ vf);
            3'b110:  t = ~cf;
            3'b111:  t = cf;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and Moore decode of selects and raw strobes
    always_comb begin
        state_n    = FETCH;
        alu_op     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                AdrSrc    = 1'b0;
                ir_write  = 1'b1;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
                state_n   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_n = MEMADR;
                    OP_RTYPE:  state_n = EXECR;
                    OP_ITYPE:  state_n = EXECI;
                    OP_JAL:    state_n = JAL;
                    OP_BRANCH: state_n = BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        state_n    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
                state_n   = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_n   = FETCH;
            end
            MEMWRITE: begin
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                state_n   = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
                state_n = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_n = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                reg_write = 1'b1;
                state_n   = FETCH;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b00;
                pc_update = 1'b1;
                state_n   = ALUWB;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                alu_op    = 2'b01;
                ResultSrc = 2'b00;
                branch    = 1'b1;
                state_n   = FETCH;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Immediate format depends only on the opcode so it is valid in every state
    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign ALUControl = alu_decode(alu_op, funct3, op[5], funct7b5);

    // Strobes are held low for as long as reset is asserted
    assign IRWrite  = ir_write & ~reset;
    assign PCWrite  = (pc_update | (branch & branch_taken(funct3, Z, N, V, C))) & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign illegal  = illegal_op & ~reset;
    assign state    = state_q;

endmodule
